// File: rtl/mips_alu_pkg.sv
// Shared types for the multiply/divide unit: operation codes, FSM states and
// small decode helpers used by the unit and its testbench.
package mips_alu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Signed operations take operand magnitudes and fix signs at the end.
    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == MULT) || (o == DIV);
    endfunction

    function automatic logic op_is_mul(input muldiv_op_t o);
        return (o == MULT) || (o == MULTU);
    endfunction

    function automatic logic op_is_arith(input muldiv_op_t o);
        return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
    endfunction

endpackage

// File: rtl/mips_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and shift in the quotient bit.
// The quotient register initially holds the dividend and is consumed MSB first.
module mips_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // Trial subtraction; with a zero divisor every bit "fits" and the
    // remainder ends up equal to the dividend.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        fits    = (shifted >= {1'b0, divisor_i});
        rem_o   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU/DIV/DIVU run one bit per cycle (IDLE -> CALC -> FIX -> IDLE);
// MTHI/MTLO write HI/LO directly.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies bypass CALC using a
// single-cycle multiplier and complete one cycle after accept.
module mips_muldiv_unit
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc_hi/acc_lo: multiply = {partial product, multiplier},
    //                divide   = {partial remainder, dividend/quotient}
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    // Multiplicand or divisor magnitude.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    muldiv_op_t       op_in;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_rem, div_quo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             last_iter;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
`endif

    // Operand decode: magnitudes for signed ops, raw values otherwise.
    always_comb begin
        op_in  = muldiv_op_t'(op);
        rs_neg = op_is_signed(op_in) & rs_content[WIDTH-1];
        rt_neg = op_is_signed(op_in) & rt_content[WIDTH-1];
        rs_mag = rs_neg ? -rs_content : rs_content;
        rt_mag = rt_neg ? -rt_content : rt_content;
    end

`ifdef MULDIV_FAST_MUL_EN
    // Single-cycle magnitude product, loaded straight into the accumulator.
    always_comb begin
        fast_prod = (2*WIDTH)'(rs_mag) * (2*WIDTH)'(rt_mag);
    end
`endif

    // Shift-add multiply step: add multiplicand when the multiplier LSB is set,
    // then shift the whole accumulator right by one.
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    end

    mips_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i     (acc_hi_q),
        .quo_i     (acc_lo_q),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    // Sign correction of the magnitude results for the FIX cycle.
    always_comb begin
        prod_fix  = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_fix   = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state and datapath control for the IDLE/CALC/FIX sequence.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                // Abort alongside start in IDLE suppresses the request.
                if (start && !abort) begin
                    if (op_is_arith(op_in)) begin
                        dbz_d     = 1'b0;
                        op_d      = op_in;
                        cnt_d     = '0;
                        neg_res_d = rs_neg ^ rt_neg;
                        neg_rem_d = rs_neg;
                        acc_hi_d  = '0;
                        if (op_is_mul(op_in)) begin
                            acc_lo_d = rt_mag;
                            opnd_d   = rs_mag;
                        end else begin
                            acc_lo_d = rs_mag;
                            opnd_d   = rt_mag;
                        end
                        state_d = CALC;
`ifdef MULDIV_FAST_MUL_EN
                        if (op_is_mul(op_in)) begin
                            {acc_hi_d, acc_lo_d} = fast_prod;
                            state_d              = FIX;
                        end
`else
                        state_d = CALC;
`endif
                    end else if (op_in == MTHI) begin
                        dbz_d  = 1'b0;
                        hi_d   = rs_content;
                        done_d = 1'b1;
                    end else if (op_in == MTLO) begin
                        dbz_d  = 1'b0;
                        lo_d   = rs_content;
                        done_d = 1'b1;
                    end
                end
            end

            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (op_is_mul(op_q)) begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end else begin
                        acc_hi_d = div_rem;
                        acc_lo_d = div_quo;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = FIX;
                    end
                end
            end

            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (op_is_mul(op_q)) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        // The remainder path already equals the dividend when
                        // the divisor is zero; only the quotient is forced.
                        hi_d  = rem_fix;
                        lo_d  = (opnd_q == '0) ? '1 : quo_fix;
                        dbz_d = (opnd_q == '0);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= MULT;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed testbench for mips_muldiv_unit. Expected multiply latency follows
// the MULDIV_FAST_MUL_EN build macro.
module tb_mips_muldiv_unit;
    import mips_alu_pkg::*;

    localparam int unsigned WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = WIDTH + 1;
`endif
    localparam int DIV_LAT = WIDTH + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  rs;
    logic [WIDTH-1:0]  rt;
    logic              abort;
    logic              busy;
    logic              done;
    logic              dbz;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(
        .WIDTH(WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs_content  (rs),
        .rt_content  (rt),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .div_by_zero (dbz),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one clock; returns at the falling edge after accept.
    task automatic issue(input muldiv_op_t o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_arith(input string tag, input muldiv_op_t o,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo,
                             input logic edbz, input int elat);
        int cyc;
        issue(o, a, b);
        check({tag, " busy"}, 64'(busy), 64'(1));
        wait_done(cyc);
        check({tag, " latency"}, 64'(cyc), 64'(elat));
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
        check({tag, " dbz"}, 64'(dbz), 64'(edbz));
        check({tag, " busy_end"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'(0));
    endtask

    initial begin
        int cyc;
        int saw;
        rst_n = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        op    = 3'd0;
        rs    = '0;
        rt    = '0;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst dbz",  64'(dbz),  64'(0));
        check("rst hi",   64'(hi),   64'(0));
        check("rst lo",   64'(lo),   64'(0));
        rst_n = 1'b1;

        run_arith("mult_neg2x3", MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, MUL_LAT);
        run_arith("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT);
        run_arith("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_LAT);
        run_arith("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, DIV_LAT);
        run_arith("divu_by0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, DIV_LAT);

        // MTHI completes without busy and clears the sticky divide-by-zero flag.
        issue(MTHI, 32'h1234_5678, 32'd0);
        check("mthi done", 64'(done), 64'(1));
        check("mthi busy", 64'(busy), 64'(0));
        check("mthi hi",   64'(hi),   64'(32'h1234_5678));
        check("mthi dbz",  64'(dbz),  64'(0));
        @(negedge clk);
        check("mthi done_pulse", 64'(done), 64'(0));
        issue(MTLO, 32'h9ABC_DEF0, 32'd0);
        check("mtlo done", 64'(done), 64'(1));
        check("mtlo lo",   64'(lo),   64'(32'h9ABC_DEF0));

        // Abort mid-operation; a second start while busy is dropped.
`ifdef MULDIV_FAST_MUL_EN
        issue(DIVU, 32'd30, 32'd6);
`else
        issue(MULTU, 32'd5, 32'd6);
`endif
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = MTLO;
        rs    = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        check("abort busy_mid", 64'(busy), 64'(1));
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw++;
        end
        check("abort no_done", 64'(saw), 64'(0));
        check("abort hi", 64'(hi), 64'(32'h1234_5678));
        check("abort lo", 64'(lo), 64'(32'h9ABC_DEF0));

        // Abort together with start in IDLE: nothing is accepted.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        op    = MTHI;
        rs    = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_start done", 64'(done), 64'(0));
        check("abort_start hi",   64'(hi),   64'(32'h1234_5678));

        run_arith("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_LAT);

        // A start presented in the done cycle is accepted.
        issue(MULTU, 32'd7, 32'd9);
        wait_done(cyc);
        check("b2b mul latency", 64'(cyc), 64'(MUL_LAT));
        check("b2b mul lo", 64'(lo), 64'(63));
        start = 1'b1;
        op    = DIVU;
        rs    = 32'd63;
        rt    = 32'd8;
        @(negedge clk);
        start = 1'b0;
        check("b2b accept busy", 64'(busy), 64'(1));
        wait_done(cyc);
        check("b2b div latency", 64'(cyc), 64'(DIV_LAT));
        check("b2b div lo", 64'(lo), 64'(7));
        check("b2b div hi", 64'(hi), 64'(7));

        // Asynchronous reset in the middle of a divide.
        issue(DIV, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst busy", 64'(busy), 64'(0));
        check("async_rst done", 64'(done), 64'(0));
        check("async_rst hi",   64'(hi),   64'(0));
        check("async_rst lo",   64'(lo),   64'(0));
        check("async_rst dbz",  64'(dbz),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst busy", 64'(busy), 64'(0));
        check("post_rst lo",   64'(lo),   64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
